// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types and ASCII constants for the port-number line parser
package cfg_pkg;

   typedef enum logic [2:0] {
      ERR_OK       = 3'd0,
      ERR_BAD_CHAR = 3'd1,
      ERR_OVERFLOW = 3'd2,
      ERR_TOO_LONG = 3'd3,
      ERR_ZERO     = 3'd4,
      ERR_TAKEN    = 3'd5
   } err_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= ASCII_0) && (c <= ASCII_9);
   endfunction

endpackage

// File: rtl/cfg_port_parser_if.sv
// rtl/cfg_port_parser_if.sv - byte-in / result-out handshake bundle of the port parser
interface cfg_port_parser_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [15:0] reserved_port;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_port;
   logic [2:0]  res_err;

   modport master (
      output in_valid, in_data, reserved_port, res_ready,
      input  in_ready, res_valid, res_port, res_err
   );

   modport slave (
      input  in_valid, in_data, reserved_port, res_ready,
      output in_ready, res_valid, res_port, res_err
   );
endinterface

// File: rtl/dec_digit_acc.sv
// rtl/dec_digit_acc.sv - combinational acc*10+digit step with 16-bit overflow detect
module dec_digit_acc (
   input  logic [16:0] acc,
   input  logic [3:0]  digit,
   output logic [16:0] acc_next,
   output logic        overflow
);
   // acc never exceeds 65535 on entry, so 21 bits hold the full product plus digit
   logic [20:0] prod;

   assign prod     = ({4'd0, acc} * 21'd10) + {17'd0, digit};
   assign overflow = prod > 21'd65535;
   assign acc_next = prod[16:0];
endmodule

// File: rtl/cfg_port_parser.sv
// rtl/cfg_port_parser.sv - parses an LF-terminated ASCII decimal line into a validated port number
module cfg_port_parser
   import cfg_pkg::*;
#(
   parameter int DEFAULT_PORT = 22202,
   parameter int MAX_DIGITS   = 5
) (
   input logic clk,
   input logic rst,
   cfg_port_parser_if.slave bus
);
   localparam int CW = $clog2(MAX_DIGITS + 1);

   state_e        state, state_d;
   logic [16:0]   acc, acc_d;
   logic [CW-1:0] count, count_d;
   err_e          err, err_d;
   logic [15:0]   port_q, port_d;
   err_e          rerr_q, rerr_d;

   logic [16:0]   acc_next;
   logic          acc_ovf;
   logic          accept;
   logic          is_lf;
   logic          dig;

   dec_digit_acc u_acc (
      .acc      (acc),
      .digit    (bus.in_data[3:0]),
      .acc_next (acc_next),
      .overflow (acc_ovf)
   );

   assign accept = bus.in_valid && bus.in_ready;
   assign is_lf  = bus.in_data == ASCII_LF;
   assign dig    = is_digit(bus.in_data);

   // in_ready is gated by rst so nothing is accepted while reset is held
   assign bus.in_ready  = !rst && (state != S_DONE);
   assign bus.res_valid = state == S_DONE;
   assign bus.res_port  = port_q;
   assign bus.res_err   = rerr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         acc    <= '0;
         count  <= '0;
         err    <= ERR_OK;
         port_q <= '0;
         rerr_q <= ERR_OK;
      end else begin
         state  <= state_d;
         acc    <= acc_d;
         count  <= count_d;
         err    <= err_d;
         port_q <= port_d;
         rerr_q <= rerr_d;
      end
   end

   always_comb begin
      state_d = state;
      acc_d   = acc;
      count_d = count;
      err_d   = err;
      port_d  = port_q;
      rerr_d  = rerr_q;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (dig) begin
                  acc_d   = {13'd0, bus.in_data[3:0]};
                  count_d = CW'(1);
                  err_d   = ERR_OK;
                  state_d = S_ACCUM;
               end else if (is_lf) begin
                  port_d  = 16'(DEFAULT_PORT);
                  rerr_d  = ERR_OK;
                  state_d = S_DONE;
               end else begin
                  err_d   = ERR_BAD_CHAR;
                  state_d = S_DRAIN;
               end
            end
         end
         S_ACCUM: begin
            if (accept) begin
               if (dig) begin
                  if (count == CW'(MAX_DIGITS)) begin
                     err_d   = ERR_TOO_LONG;
                     state_d = S_DRAIN;
                  end else if (acc_ovf) begin
                     err_d   = ERR_OVERFLOW;
                     state_d = S_DRAIN;
                  end else begin
                     acc_d   = acc_next;
                     count_d = count + CW'(1);
                  end
               end else if (is_lf) begin
                  state_d = S_DONE;
                  port_d  = '0;
                  if (acc == 17'd0)
                     rerr_d = ERR_ZERO;
                  else if (acc == {1'b0, bus.reserved_port})
                     rerr_d = ERR_TAKEN;
                  else begin
                     rerr_d = ERR_OK;
                     port_d = acc[15:0];
                  end
               end else begin
                  err_d   = ERR_BAD_CHAR;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // err keeps the first failure; later bytes are only scanned for LF
            if (accept && is_lf) begin
               port_d  = '0;
               rerr_d  = err;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.res_ready) begin
               acc_d   = '0;
               count_d = '0;
               err_d   = ERR_OK;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_cfg_port_parser.sv
// tb/tb_cfg_port_parser.sv - randomized and directed self-checking bench for cfg_port_parser
module tb_cfg_port_parser;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cfg_port_parser_if bus ();

   cfg_port_parser #(.DEFAULT_PORT(22202), .MAX_DIGITS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad = 0;
   int ready_mode = 0;
   logic [18:0] exp_q[$];
   logic lf_pending = 1'b0;
   logic held = 1'b0;
   logic [15:0] held_port;
   logic [2:0] held_err;
   logic [7:0] badc [6] = '{8'h2F, 8'h3A, 8'h0D, 8'h20, 8'h61, 8'h5A};

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bq_t s2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   // Reference: scan the line's text left to right, first failure wins
   function automatic logic [18:0] model(input bq_t q, input logic [15:0] rsv);
      int val = 0;
      int n = 0;
      int e = -1;
      if (q.size() == 1) return {16'd22202, 3'd0};
      for (int i = 0; i < q.size() - 1; i++) begin
         if (e >= 0) break;
         if (q[i] < 8'h30 || q[i] > 8'h39) e = 1;
         else if (n == 5) e = 3;
         else begin
            val = val * 10 + int'(q[i] - 8'h30);
            n++;
            if (val > 65535) e = 2;
         end
      end
      if (e >= 0) return {16'd0, 3'(e)};
      if (val == 0) return {16'd0, 3'd4};
      if (val == int'(rsv)) return {16'd0, 3'd5};
      return {16'(val), 3'd0};
   endfunction

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      bus.reserved_port = 16'd0;
      bus.res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) bus.res_ready = ($urandom % 3) != 0;
         else bus.res_ready = (ready_mode == 2);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("in_ready_in_reset", int'(bus.in_ready), 0);
            exp_q.delete();
            lf_pending = 1'b0;
            held = 1'b0;
         end else begin
            check("in_ready_vs_done", int'(bus.in_ready), int'(!bus.res_valid));
            if (lf_pending) check("res_latency", int'(bus.res_valid), 1);
            if (held) begin
               check("hold_port", int'(bus.res_port), int'(held_port));
               check("hold_err", int'(bus.res_err), int'(held_err));
            end
            if (bus.res_valid) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_result: got port %0d err %0d expected none",
                           bus.res_port, bus.res_err);
               end else begin
                  check("res_port", int'(bus.res_port), int'(exp_q[0][18:3]));
                  check("res_err", int'(bus.res_err), int'(exp_q[0][2:0]));
                  if (bus.res_ready) void'(exp_q.pop_front());
               end
            end
            lf_pending = bus.in_valid && bus.in_ready && (bus.in_data == 8'h0A);
            held = bus.res_valid && !bus.res_ready;
            held_port = bus.res_port;
            held_err = bus.res_err;
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic drive_byte(input logic [7:0] b);
      int n = 0;
      logic acc = 1'b0;
      if ($urandom % 4 == 0) begin
         bus.in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data = b;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 300);
      bus.in_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL in_handshake_timeout: got no accept expected accept of %0h", b);
      end
   endtask

   task automatic send_line(input bq_t q, input logic [15:0] rsv,
                            input logic [15:0] ep, input logic [2:0] ee);
      bus.reserved_port = rsv;
      foreach (q[i]) begin
         if (q[i] == 8'h0A) exp_q.push_back({ep, ee});
         drive_byte(q[i]);
      end
   endtask

   task automatic directed(input string s, input logic [15:0] rsv,
                           input logic [15:0] ep, input logic [2:0] ee);
      bq_t q;
      q = s2q(s);
      check("model_pin", int'(model(q, rsv)), int'({ep, ee}));
      send_line(q, rsv, ep, ee);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_res_valid", int'(bus.res_valid), 0);
      check("rst_res_port", int'(bus.res_port), 0);
      check("rst_res_err", int'(bus.res_err), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bq_t q;
      logic [15:0] rsv;
      logic [18:0] e;
      int kind;
      int v;
      @(posedge clk);
      #1;
      do_reset(3);

      directed("22202\n", 16'd80, 16'd22202, 3'd0);
      directed("\n", 16'd80, 16'd22202, 3'd0);
      directed("80\n", 16'd80, 16'd0, 3'd5);
      directed("00080\n", 16'd80, 16'd0, 3'd5);
      directed("65536\n", 16'd80, 16'd0, 3'd2);
      directed("65535\n", 16'd80, 16'd65535, 3'd0);
      directed("000080\n", 16'd80, 16'd0, 3'd3);
      directed("0\n", 16'd80, 16'd0, 3'd4);
      directed("8a0\n", 16'd80, 16'd0, 3'd1);
      directed("99999x\n", 16'd80, 16'd0, 3'd2);
      directed("22202\r\n", 16'd80, 16'd0, 3'd1);
      directed("/\n", 16'd80, 16'd0, 3'd1);
      directed(":9\n", 16'd80, 16'd0, 3'd1);
      wait_empty();

      ready_mode = 1;
      directed("9\n", 16'd80, 16'd9, 3'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_valid", int'(bus.res_valid), 1);
         check("hold_in_ready", int'(bus.in_ready), 0);
      end
      @(posedge clk);
      #1;
      ready_mode = 2;
      directed("443\n", 16'd80, 16'd443, 3'd0);
      wait_empty();
      ready_mode = 0;

      drive_byte(8'h32);
      drive_byte(8'h32);
      drive_byte(8'h30);
      do_reset(2);
      directed("8080\n", 16'd80, 16'd8080, 3'd0);
      wait_empty();

      ready_mode = 1;
      directed("1\n", 16'd80, 16'd1, 3'd0);
      repeat (3) @(posedge clk);
      #1;
      do_reset(1);
      ready_mode = 0;
      repeat (5) @(negedge clk);
      check("no_result_after_reset", int'(bus.res_valid), 0);
      @(posedge clk);
      #1;

      for (int k = 0; k < 200; k++) begin
         q.delete();
         rsv = 16'($urandom);
         kind = int'($urandom % 6);
         case (kind)
            0: ;
            1: repeat ($urandom_range(1, 7)) q.push_back(8'h30 + 8'($urandom % 10));
            2: q = s2q($sformatf("%0d", $urandom_range(0, 70000)));
            3: begin
               v = int'($urandom_range(1, 65535));
               rsv = 16'(v);
               q = s2q($sformatf("%0d", v));
            end
            4: begin
               q = s2q($sformatf("%0d", $urandom_range(0, 99999)));
               q.insert(int'($urandom_range(0, q.size())), badc[$urandom % 6]);
            end
            default: q = s2q($sformatf("%05d", $urandom_range(0, 999)));
         endcase
         q.push_back(8'h0A);
         e = model(q, rsv);
         send_line(q, rsv, e[18:3], e[2:0]);
      end
      wait_empty();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cfg_port_parser.md
CFG_PORT_PARSER -- requirements
Module: cfg_port_parser

Interface
REQ-001 Parameter DEFAULT_PORT, 22202, port returned when the input line is empty.
REQ-002 Parameter MAX_DIGITS, 5, maximum accepted decimal digit count, leading zeros included.
REQ-003 Port clk  in  1  sole clock; all logic SHALL be rising-edge clk.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port in_valid  in  1  ASCII byte present.
REQ-006 Port in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-007 Port in_data  in  8  ASCII byte; 0x0A (LF) terminates a line.
REQ-008 Port reserved_port  in  16  port already bound elsewhere (listen port); sampled when LF is accepted.
REQ-009 Port res_valid  out  1  result present.
REQ-010 Port res_ready  in  1  result consumed when res_valid && res_ready.
REQ-011 Port res_port  out  16  parsed port number; 0 when res_err != OK.
REQ-012 Port res_err  out  3  0 OK, 1 BAD_CHAR, 2 OVERFLOW, 3 TOO_LONG, 4 ZERO, 5 TAKEN.

Function
REQ-013 The FSM SHALL have the states IDLE, ACCUM, DRAIN and DONE.
REQ-014 in_ready SHALL be 1 in IDLE, ACCUM and DRAIN, and 0 in DONE.
REQ-015 IDLE: digit '0'..'9' -> acc=digit, count=1, ACCUM; LF -> result DEFAULT_PORT/OK, DONE; any other byte -> err=BAD_CHAR, DRAIN.
REQ-016 ACCUM: digit -> acc=acc*10+digit, count+1; LF -> DONE with result per REQ-019.
REQ-017 The accumulator SHALL be 17 bits wide; an update producing a value >65535 SHALL set err=OVERFLOW and go to DRAIN.
REQ-018 A digit arriving when count==MAX_DIGITS SHALL set err=TOO_LONG and go to DRAIN; a non-digit, non-LF byte in ACCUM SHALL set err=BAD_CHAR and go to DRAIN.
REQ-019 On LF in ACCUM: acc==0 -> ZERO; else acc==reserved_port -> TAKEN; else OK with res_port=acc[15:0].
REQ-020 DRAIN: all bytes SHALL be discarded until LF, then DONE; the first recorded error SHALL win.
REQ-021 res_valid SHALL assert in the cycle after the LF handshake (latency 1), and res_port/res_err SHALL be held stable while res_valid && !res_ready.
REQ-022 DONE: the res_valid && res_ready handshake SHALL return the FSM to IDLE, with in_ready=1 the next cycle; back-to-back lines SHALL therefore cost one bubble cycle each.
REQ-023 res_valid SHALL be 1 only in DONE.
REQ-024 The 0x0D (CR) byte SHALL be BAD_CHAR; no whitespace stripping SHALL be performed.

Reset
REQ-025 When rst is sampled high, the block SHALL go to IDLE and clear acc, count and the error register.
REQ-026 Reset values: in_ready=0 during reset then 1 in IDLE; res_valid=0, res_port=0, res_err=0.
REQ-027 Reset mid-line or with an unconsumed result SHALL discard all partial state; no result SHALL be emitted for that line.

Structure
REQ-028 A shared package cfg_pkg SHALL hold the err_e enum (3-bit codes), the state_e enum and the ASCII constants LF, '0' and '9'.
REQ-029 One sub-module, dec_digit_acc, SHALL perform the combinational acc*10+digit computation and the overflow flag; the FSM stays in cfg_port_parser.

Verification
REQ-030 "22202\n" with reserved_port=80 -> res_valid one cycle after LF, res_port=22202, res_err=OK.
REQ-031 "\n" -> res_port=22202 (DEFAULT_PORT), OK; "80\n" with reserved_port=80 -> res_port=0, TAKEN.
REQ-032 "65536\n" -> OVERFLOW; "65535\n" -> 65535, OK; "000080\n" -> TOO_LONG; "0\n" -> ZERO.
REQ-033 "8a0\n" -> BAD_CHAR; "99999x\n" -> OVERFLOW (the first error wins); "22202\r\n" -> BAD_CHAR.
REQ-034 res_ready held 0 for 10 cycles -> in_ready=0 and outputs stable throughout; after release, the next line "443\n" -> 443, OK.
REQ-035 rst pulsed after "220" -> no result; then "8080\n" -> 8080, OK.
